// File: rtl/exec_pkg.sv
// Shared encodings for the execute stage: ALUOp and funct codes, ALU control
// selection, multiplier FSM states and the ALU control decoder.
package exec_pkg;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_ILL   = 2'b11
    } aluop_e;

    localparam logic [5:0] FUNCT_ADD = 6'h00;
    localparam logic [5:0] FUNCT_SUB = 6'h01;
    localparam logic [5:0] FUNCT_MUL = 6'h02;
    localparam logic [5:0] FUNCT_AND = 6'h03;
    localparam logic [5:0] FUNCT_OR  = 6'h04;
    localparam logic [5:0] FUNCT_SLT = 6'h05;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_MUL = 3'd2,
        ALU_AND = 3'd3,
        ALU_OR  = 3'd4,
        ALU_SLT = 3'd5,
        ALU_ILL = 3'd6
    } alu_ctrl_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_e;

    function automatic alu_ctrl_e decode_alu(input aluop_e op, input logic [5:0] funct);
        alu_ctrl_e ctrl;
        ctrl = ALU_ILL;
        case (op)
            ALUOP_ADD: ctrl = ALU_ADD;
            ALUOP_SUB: ctrl = ALU_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: ctrl = ALU_ADD;
                    FUNCT_SUB: ctrl = ALU_SUB;
                    FUNCT_MUL: ctrl = ALU_MUL;
                    FUNCT_AND: ctrl = ALU_AND;
                    FUNCT_OR:  ctrl = ALU_OR;
                    FUNCT_SLT: ctrl = ALU_SLT;
                    default:   ctrl = ALU_ILL;
                endcase
            end
            default: ctrl = ALU_ILL;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/exec_mul.sv
// Multi-cycle multiplier: captures operands on start, counts down the latency
// and strobes done on the edge where the registered product becomes valid.
module exec_mul
    import exec_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              stall_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] product_o
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!stall_i) begin
            case (state_q)
                ST_IDLE:     if (start_i) state_d = ST_MUL_BUSY;
                ST_MUL_BUSY: if (cnt_q == CNT_ONE) state_d = ST_IDLE;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o = (state_q == ST_MUL_BUSY);
        done_o = (state_q == ST_MUL_BUSY) && (cnt_q == CNT_ONE) && !stall_i;
    end

    // Counter and operand capture; everything holds while stalled.
    always_comb begin
        cnt_d = cnt_q;
        a_d   = a_q;
        b_d   = b_q;
        if (!stall_i) begin
            if (state_q == ST_IDLE && start_i) begin
                cnt_d = CNT_LOAD;
                a_d   = a_i;
                b_d   = b_i;
            end else if (state_q == ST_MUL_BUSY) begin
                cnt_d = cnt_q - CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            a_q   <= a_d;
            b_q   <= b_d;
        end
    end

    assign product_o = a_q * b_q;

endmodule

// File: rtl/exec_stage.sv
// Execute stage: single-cycle ALU and branch resolution, with MUL optionally
// handed to a multi-cycle unit that stalls upstream via busy.
module exec_stage
    import exec_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall_flag,
    input  logic              in_valid,
    output logic              busy,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] rs,
    input  logic [DATA_W-1:0] rt,
    input  logic [DATA_W-1:0] sign_ext,
    input  logic              ALUSrc,
    input  logic [1:0]        ALUOp,
    input  logic              branch,
    output logic              out_valid,
    output logic [DATA_W-1:0] result_out,
    output logic [DATA_W-1:0] address,
    output logic [DATA_W-1:0] offset,
    output logic [DATA_W-1:0] pcout,
    output logic              zero,
    output logic              taken,
    output logic              illegal
);

    localparam logic MUL_MULTI = (MUL_CYCLES > 1);

    aluop_e            aluop_sel;
    alu_ctrl_e         alu_ctrl;
    logic              accept;
    logic              start_mul;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mul_fast;
    logic [DATA_W-1:0] off_calc;
    logic [DATA_W-1:0] addr_calc;
    logic [DATA_W-1:0] pcn_calc;
    logic              zero_calc;
    logic              taken_calc;

    logic              mul_busy;
    logic              mul_done;
    logic [DATA_W-1:0] mul_product;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [DATA_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] offset_q, offset_d;
    logic [DATA_W-1:0] pcout_q, pcout_d;
    logic              zero_q, zero_d;
    logic              taken_q, taken_d;
    logic              illegal_q, illegal_d;

    assign aluop_sel = aluop_e'(ALUOp);
    assign alu_ctrl  = decode_alu(aluop_sel, sign_ext[5:0]);
    assign accept    = in_valid && !busy && !stall_flag;
    assign start_mul = accept && (alu_ctrl == ALU_MUL) && MUL_MULTI;

    // Loads/stores (ALUOp 00) always add the immediate, whatever ALUSrc says.
    assign opb = (ALUSrc || aluop_sel == ALUOP_ADD) ? sign_ext : rt;

    generate
        if (MUL_CYCLES == 1) begin : g_mul_comb
            assign mul_fast = rs * opb;
        end else begin : g_mul_seq
            assign mul_fast = '0;
        end
    endgenerate

    always_comb begin
        alu_result = '0;
        case (alu_ctrl)
            ALU_ADD: alu_result = rs + opb;
            ALU_SUB: alu_result = rs - opb;
            ALU_MUL: alu_result = mul_fast;
            ALU_AND: alu_result = rs & opb;
            ALU_OR:  alu_result = rs | opb;
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(rs) < $signed(opb))};
            default: alu_result = '0;
        endcase
    end

    assign off_calc   = {sign_ext[DATA_W-3:0], 2'b00};
    assign addr_calc  = pc + off_calc;
    assign zero_calc  = (rs == rt);
    assign taken_calc = branch && zero_calc;
    assign pcn_calc   = taken_calc ? addr_calc : pc;

    exec_mul #(
        .DATA_W     (DATA_W),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk       (clk),
        .rst_ni    (reset),
        .stall_i   (stall_flag),
        .start_i   (start_mul),
        .a_i       (rs),
        .b_i       (opb),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    // Branch fields of a multi-cycle MUL update at acceptance; its result
    // and the out_valid pulse follow when the multiplier finishes.
    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        address_d   = address_q;
        offset_d    = offset_q;
        pcout_d     = pcout_q;
        zero_d      = zero_q;
        taken_d     = taken_q;
        illegal_d   = illegal_q;
        if (!stall_flag) begin
            out_valid_d = 1'b0;
            if (mul_done) begin
                result_d    = mul_product;
                out_valid_d = 1'b1;
            end else if (accept) begin
                address_d = addr_calc;
                offset_d  = off_calc;
                pcout_d   = pcn_calc;
                zero_d    = zero_calc;
                taken_d   = taken_calc;
                illegal_d = (alu_ctrl == ALU_ILL);
                if (!start_mul) begin
                    result_d    = alu_result;
                    out_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            address_q   <= '0;
            offset_q    <= '0;
            pcout_q     <= '0;
            zero_q      <= 1'b0;
            taken_q     <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            address_q   <= address_d;
            offset_q    <= offset_d;
            pcout_q     <= pcout_d;
            zero_q      <= zero_d;
            taken_q     <= taken_d;
            illegal_q   <= illegal_d;
        end
    end

    assign busy       = mul_busy;
    assign out_valid  = out_valid_q;
    assign result_out = result_q;
    assign address    = address_q;
    assign offset     = offset_q;
    assign pcout      = pcout_q;
    assign zero       = zero_q;
    assign taken      = taken_q;
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_exec_stage.sv
// Scoreboard bench for exec_stage: a driver pushes model results on acceptance,
// a negedge monitor pops and compares on every counted out_valid.
module tb_exec_stage;

    localparam int DATA_W     = 32;
    localparam int MUL_CYCLES = 4;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              stall_flag = 1'b0;
    logic              in_valid = 1'b0;
    logic              busy;
    logic [DATA_W-1:0] pc = '0, rs = '0, rt = '0, sign_ext = '0;
    logic              ALUSrc = 1'b0;
    logic [1:0]        ALUOp = 2'b00;
    logic              branch = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] result_out, address, offset, pcout;
    logic              zero, taken, illegal;

    exec_stage #(.DATA_W(DATA_W), .MUL_CYCLES(MUL_CYCLES)) dut (
        .clk(clk), .reset(reset), .stall_flag(stall_flag), .in_valid(in_valid), .busy(busy),
        .pc(pc), .rs(rs), .rt(rt), .sign_ext(sign_ext),
        .ALUSrc(ALUSrc), .ALUOp(ALUOp), .branch(branch),
        .out_valid(out_valid), .result_out(result_out), .address(address), .offset(offset),
        .pcout(pcout), .zero(zero), .taken(taken), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] result, address, offset, pcout;
        logic        zero, taken, illegal;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   txn = 0;
    bit   stall_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference: instruction semantics written straight from the ISA rules.
    function automatic exp_t model(input logic [31:0] p, a, b, se, input logic src,
                                   input logic [1:0] op, input logic br);
        exp_t e;
        logic [31:0] opb;
        logic [63:0] prod;
        opb = (src || op == 2'b00) ? se : b;
        prod = {32'b0, a} * {32'b0, opb};
        e.illegal = 1'b0;
        e.result  = 32'd0;
        case (op)
            2'b00: e.result = a + opb;
            2'b01: e.result = a - opb;
            2'b10: begin
                case (se[5:0])
                    6'd0: e.result = a + opb;
                    6'd1: e.result = a - opb;
                    6'd2: e.result = prod[31:0];
                    6'd3: e.result = a & opb;
                    6'd4: e.result = a | opb;
                    6'd5: e.result = ($signed(a) < $signed(opb)) ? 32'd1 : 32'd0;
                    default: e.illegal = 1'b1;
                endcase
            end
            default: e.illegal = 1'b1;
        endcase
        e.offset  = se * 32'd4;
        e.address = p + e.offset;
        e.zero    = (a == b);
        e.taken   = br && e.zero;
        e.pcout   = e.taken ? e.address : p;
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        if (stall_en) stall_flag = ($urandom_range(0, 4) == 0);
    endtask

    task automatic issue(input logic [31:0] p, a, b, se, input logic src,
                         input logic [1:0] op, input logic br, output int waited);
        bit acc;
        pc = p; rs = a; rt = b; sign_ext = se; ALUSrc = src; ALUOp = op; branch = br;
        in_valid = 1'b1;
        waited = 0;
        forever begin
            acc = !busy && !stall_flag;
            step();
            if (acc) break;
            waited++;
            if (waited > 200) break;
        end
        if (acc) sb_q.push_back(model(p, a, b, se, src, op, br));
        else chk("accept_timeout", 64'(waited), 64'd0);
        in_valid = 1'b0;
    endtask

    // Monitor: a pulse counts on the cycle where it is visible and not stalled.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset && out_valid && !stall_flag) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    txn++;
                    chk("result_out", 64'(result_out), 64'(e.result));
                    chk("address", 64'(address), 64'(e.address));
                    chk("offset", 64'(offset), 64'(e.offset));
                    chk("pcout", 64'(pcout), 64'(e.pcout));
                    chk("zero", 64'(zero), 64'(e.zero));
                    chk("taken", 64'(taken), 64'(e.taken));
                    chk("illegal", 64'(illegal), 64'(e.illegal));
                    $display("txn %0d: result=%h addr=%h offset=%h pcout=%h zero=%b taken=%b illegal=%b",
                             txn, result_out, address, offset, pcout, zero, taken, illegal);
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int w, n, gap;
        logic [31:0] p, a, b, se;
        logic [5:0]  f;
        logic [1:0]  op;
        logic        src, br;

        // Reset state, checked between edges while reset is held low.
        #3;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_result", 64'(result_out), 64'd0);
        chk("rst_address", 64'(address), 64'd0);
        chk("rst_offset", 64'(offset), 64'd0);
        chk("rst_pcout", 64'(pcout), 64'd0);
        chk("rst_flags", 64'({zero, taken, illegal}), 64'd0);
        #9 reset = 1'b1;

        // R-type ADD 5+7, accepted on the first edge after release.
        issue(32'h0, 32'd5, 32'd7, 32'h0, 1'b0, 2'b10, 1'b0, w);
        chk("first_edge_accept", 64'(w), 64'd0);
        chk("add_out_valid", 64'(out_valid), 64'd1);
        chk("add_result", 64'(result_out), 64'd12);
        chk("add_busy", 64'(busy), 64'd0);

        // MUL 0x10000*0x10000: busy for MUL_CYCLES-1 cycles, truncated result.
        issue(32'h20, 32'h10000, 32'h10000, 32'h2, 1'b0, 2'b10, 1'b0, w);
        n = 0;
        while (busy && n < 50) begin
            chk("mul_no_early_valid", 64'(out_valid), 64'd0);
            step();
            n++;
        end
        chk("mul_busy_cycles", 64'(n), 64'(MUL_CYCLES - 1));
        chk("mul_out_valid", 64'(out_valid), 64'd1);
        chk("mul_result", 64'(result_out), 64'd0);
        step();
        chk("mul_single_pulse", 64'(out_valid), 64'd0);

        // BEQ with negative offset.
        issue(32'h100, 32'd9, 32'd9, 32'hFFFF_FFFF, 1'b0, 2'b01, 1'b1, w);
        chk("beq_zero", 64'(zero), 64'd1);
        chk("beq_taken", 64'(taken), 64'd1);
        chk("beq_offset", 64'(offset), 64'hFFFF_FFFC);
        chk("beq_pcout", 64'(pcout), 64'h0FC);

        // Three stalled cycles mid-MUL push the result back by three edges.
        issue(32'h40, 32'd3, 32'd5, 32'h2, 1'b0, 2'b10, 1'b0, w);
        step();
        stall_flag = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rs = $urandom; rt = $urandom;
            step();
            chk("stall_busy_frozen", 64'(busy), 64'd1);
            chk("stall_valid_frozen", 64'(out_valid), 64'd0);
        end
        stall_flag = 1'b0;
        n = 4;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        chk("stall_mul_latency", 64'(n), 64'(MUL_CYCLES - 1 + 3));
        stall_flag = 1'b1;
        step();
        chk("stall_holds_out_valid", 64'(out_valid), 64'd1);
        chk("stall_holds_result", 64'(result_out), 64'd15);
        stall_flag = 1'b0;
        step();

        // Asynchronous reset pulse between edges mid-MUL discards the MUL.
        issue(32'h40, 32'd7, 32'd9, 32'h2, 1'b0, 2'b10, 1'b0, w);
        step();
        #1 reset = 1'b0;
        sb_q.delete();
        #1;
        chk("async_rst_busy", 64'(busy), 64'd0);
        chk("async_rst_address", 64'(address), 64'd0);
        chk("async_rst_pcout", 64'(pcout), 64'd0);
        chk("async_rst_offset", 64'(offset), 64'd0);
        #1 reset = 1'b1;
        for (int i = 0; i < MUL_CYCLES + 2; i++) begin
            step();
            chk("no_valid_after_reset", 64'(out_valid), 64'd0);
        end
        issue(32'h80, 32'd23, 32'd0, 32'd100, 1'b0, 2'b00, 1'b0, w);
        chk("post_reset_add_valid", 64'(out_valid), 64'd1);
        chk("post_reset_add_result", 64'(result_out), 64'd123);

        // Unknown funct.
        issue(32'h10, 32'd44, 32'd55, 32'h3F, 1'b0, 2'b10, 1'b0, w);
        chk("illegal_flag", 64'(illegal), 64'd1);
        chk("illegal_result", 64'(result_out), 64'd0);
        chk("illegal_valid", 64'(out_valid), 64'd1);
        step();

        // Randomized traffic with random stalls and idle gaps.
        stall_en = 1'b1;
        for (int i = 0; i < 200; i++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                rs = $urandom; rt = $urandom; sign_ext = $urandom; ALUOp = 2'($urandom_range(0, 3));
                step();
            end
            p = $urandom;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            case ($urandom_range(0, 3))
                0:       f = 6'h3F;
                1:       f = 6'($urandom_range(6, 62));
                default: f = 6'($urandom_range(0, 5));
            endcase
            se  = ($urandom & 32'hFFFF_FFC0) | {26'd0, f};
            op  = ($urandom_range(0, 9) < 5) ? 2'b10 : 2'($urandom_range(0, 3));
            src = ($urandom_range(0, 3) == 0);
            br  = 1'($urandom_range(0, 1));
            issue(p, a, b, se, src, op, br, w);
        end

        stall_en = 1'b0;
        stall_flag = 1'b0;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        step();
        chk("drain_empty", 64'(sb_q.size()), 64'd0);
        chk("final_busy", 64'(busy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exec_stage.md
EXEC_STAGE -- requirements
Module: exec_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32: datapath width in bits; legal range 8 to 64.
REQ-002 SHALL have parameter MUL_CYCLES, default 4: MUL latency in clock edges; legal range 1 to 16.
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port stall_flag  input  1  freezes all internal state and outputs while 1.
REQ-006 SHALL have port in_valid  input  1  instruction present on the operand inputs.
REQ-007 SHALL have port busy  output  1  MUL in progress; upstream holds the next instruction.
REQ-008 SHALL have ports pc, rs, rt, sign_ext  input  DATA_W each  PC, operand A, operand B and extended immediate.
REQ-009 SHALL have ports ALUSrc  input  1; ALUOp  input  2; branch  input  1; all from the control unit.
REQ-010 SHALL have port out_valid  output  1  result registers hold a new instruction.
REQ-011 SHALL have ports result_out, address, offset, pcout  output  DATA_W each  ALU result, branch target, shifted offset and next PC.
REQ-012 SHALL have ports zero, taken, illegal  output  1 each  equality, branch taken and unknown funct.

Function
REQ-013 SHALL accept an instruction on a rising edge only when in_valid=1, busy=0 and stall_flag=0.
REQ-014 SHALL select operand B as sign_ext when ALUSrc=1 or ALUOp=00, and as rt otherwise.
REQ-015 SHALL decode ALUOp 00 as ADD, 01 as SUB and 10 as R-type using funct=sign_ext[5:0]; ALUOp 11 SHALL set illegal.
REQ-016 SHALL decode R-type funct 000000 as ADD, 000001 as SUB, 000010 as MUL, 000011 as AND, 000100 as OR and 000101 as signed SLT.
REQ-017 SHALL, for any other funct, set illegal=1 and result_out=0.
REQ-018 SHALL compute all arithmetic modulo 2^DATA_W; MUL SHALL return the low DATA_W bits of the product.
REQ-019 SHALL compute zero as (rs == rt), independent of ALUSrc.
REQ-020 SHALL compute offset as sign_ext shifted left by 2 and address as pc + offset, both wrapping modulo 2^DATA_W.
REQ-021 SHALL set taken = branch AND zero, and pcout = address when taken and pc otherwise.
REQ-022 SHALL give every non-MUL op a latency of 1: outputs and out_valid=1 appear on the accepting edge.
REQ-023 SHALL implement two states, IDLE and MUL_BUSY.
REQ-024 SHALL move IDLE to MUL_BUSY when it accepts a MUL with MUL_CYCLES>1, and load a counter with MUL_CYCLES-1.
REQ-025 SHALL hold busy=1 in MUL_BUSY and decrement the counter on each non-stalled edge.
REQ-026 SHALL, on the edge where the counter reaches 0, register the MUL result, pulse out_valid and return to IDLE.
REQ-027 SHALL treat MUL_CYCLES=1 as a single-cycle op that never asserts busy.
REQ-028 SHALL drive out_valid=1 for exactly one non-stalled cycle per instruction and 0 otherwise.
REQ-029 SHALL ignore in_valid while busy=1.
REQ-030 SHALL, while stall_flag=1, hold the state, counter, captured operands and all outputs, including out_valid, unchanged.
REQ-031 SHALL capture operands at acceptance so that input changes during MUL_BUSY do not affect the result.

Reset
REQ-032 SHALL, while reset=0, force IDLE, counter=0, busy=0, out_valid=0 and all data and flag outputs to 0, independent of clk.
REQ-033 SHALL, on reset asserted mid-MUL, discard the operation with no out_valid pulse after release.
REQ-034 SHALL accept an instruction on the first rising edge after reset deasserts.

Structure
REQ-035 SHALL take ALUOp codes, funct codes, the ALU-control enum and the state enum from shared package exec_pkg.
REQ-036 SHALL place the multi-cycle multiplier (counter, captured operands, done strobe) in sub-module exec_mul, instantiated once.

Verification
REQ-037 SHALL cover: DATA_W=32, R-type ADD rs=5, rt=7 -> next edge out_valid=1, result_out=12, busy=0.
REQ-038 SHALL cover: MUL_CYCLES=4, MUL rs=0x10000, rt=0x10000 -> busy=1 for 3 cycles, then result_out=0 (truncated) with one out_valid pulse.
REQ-039 SHALL cover: BEQ rs=rt=9, sign_ext=0xFFFFFFFF, pc=0x100, branch=1 -> zero=1, taken=1, offset=0xFFFFFFFC, pcout=0xFC.
REQ-040 SHALL cover: stall_flag=1 for 3 cycles mid-MUL -> outputs and counter frozen; result arrives 3 cycles later than unstalled.
REQ-041 SHALL cover: reset=0 pulse between clock edges during MUL_BUSY -> outputs 0 at once; no out_valid after release; a new ADD succeeds.
REQ-042 SHALL cover: funct=0x3F with ALUOp=10 -> illegal=1, result_out=0, out_valid=1.
